inst_fetch_buffer: RTL and testbench

Instruction fetch buffer between the program counter / instruction ROM and the decoder/controller. It does three things:
- Tracks the one-cycle read latency of the synchronous instruction ROM.
- Pairs each returned instruction word with the address that fetched it.
- Queues the pairs in a small FIFO and presents them to the decoder over a valid/ready handshake.

It asserts `stall` to make the pc stage hold its address when the buffer cannot take more, and drops everything on `flush`.

---
 rtl/if_pkg.sv | 15 +
 rtl/inst_fifo.sv | 70 +++++++
 rtl/inst_fetch_buffer.sv | 79 +++++++
 tb/tb_inst_fetch_buffer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared constants and the fetch entry type used by the pc stage, the fetch
// buffer and the decoder.
package if_pkg;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MEM_BYTES = 1024;

  // One fetched instruction paired with the byte address that fetched it.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } if_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} pairs. Pointers wrap modulo
// DEPTH (a power of two); clear empties the queue and outranks push/pop.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [W-1:0]                 head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state for storage, pointers and occupancy; clear wins over everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is zeroed on reset so the head reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: tracks the one-cycle ROM latency, pairs returned
// words with their fetch address, queues them and hands them to the decoder.
module inst_fetch_buffer
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = if_pkg::AW,
  parameter int DW    = if_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_addr,
  input  logic          pc_ena,
  input  logic [DW-1:0] rom_data,
  output logic          stall,
  input  logic          flush,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH+1);

  logic          req_vld_q, req_vld_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          accept;
  logic          push;
  logic          pop;
  logic [AW+DW-1:0] head;

  // Stall reserves a FIFO slot for every in-flight fetch, using registered
  // state only so that neither inst_ready nor flush reaches the pc stage.
  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, req_vld_q};
    stall     = (occupancy >= (CW+1)'(DEPTH));
  end

  // Request tracking plus push/pop qualification; flush cancels all of them.
  always_comb begin
    accept     = pc_ena && !stall && !flush;
    req_vld_d  = accept;
    req_pc_d   = accept ? pc_addr : req_pc_q;
    inst_valid = (count != '0);
    push       = req_vld_q && !flush;
    pop        = inst_valid && inst_ready && !flush;
  end

  // Registers remembering which address the ROM word arriving next belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld_q <= 1'b0;
      req_pc_q  <= '0;
    end else begin
      req_vld_q <= req_vld_d;
      req_pc_q  <= req_pc_d;
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data ({req_pc_q, rom_data}),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign inst_pc = head[AW+DW-1:DW];
  assign inst    = head[DW-1:0];

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer. A queue-based reference model of
// accepted fetches predicts valid, head and stall each cycle.
module tb_inst_fetch_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_ena;
  logic [31:0] rom_data;
  logic        stall;
  logic        flush;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  bit          inflight;
  logic [31:0] inflight_pc;
  logic [31:0] cur_pc;
  bit          stream_en;

  inst_fetch_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_addr    (pc_addr),
    .pc_ena     (pc_ena),
    .rom_data   (rom_data),
    .stall      (stall),
    .flush      (flush),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM: word = address + 0x1000, one cycle latency.
  initial rom_data = 32'h0;
  always @(posedge clk) if (pc_ena) rom_data <= pc_addr + 32'h1000;

  function automatic bit exp_stall();
    return (exp_q.size() + int'(inflight)) >= 4;
  endfunction

  // Advance one clock: update the reference model and the pc stage.
  task automatic cycle();
    bit acc;
    bit popv;
    acc  = pc_ena && !exp_stall() && !flush && !rst;
    popv = (exp_q.size() != 0) && inst_ready;
    @(posedge clk);
    if (rst || flush) begin
      exp_q.delete();
      inflight = 0;
    end else begin
      if (popv) void'(exp_q.pop_front());
      if (inflight) exp_q.push_back(inflight_pc);
      inflight    = acc;
      inflight_pc = pc_addr;
    end
    if (acc) cur_pc += 32'd4;
    #1;
    pc_addr = cur_pc;
    pc_ena  = stream_en && (cur_pc < 32'd1024);
  endtask

  task automatic set_pc(input logic [31:0] a);
    cur_pc  = a;
    pc_addr = a;
    pc_ena  = stream_en && (a < 32'd1024);
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; inst_ready = 0; stream_en = 0; pc_ena = 0;
    cycle();
    cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; inst_ready = 0; stream_en = 0; pc_ena = 0;
    pc_addr = 32'h0; cur_pc = 32'h0;
    cycle();
    checks++;
    if (stall !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_values: stall=%b valid=%b inst=%h pc=%h required 0/0/0/0",
               stall, inst_valid, inst, inst_pc);
    end
    cycle();
    rst = 0;
  endtask

  task automatic test_streaming();
    do_reset();
    stream_en = 1; inst_ready = 1; set_pc(32'h0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (inst_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("[TB] FAIL stream_valid[%0d]: got %b required %b", i, inst_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (inst_pc !== exp_q[0] || inst !== exp_q[0] + 32'h1000) begin
          errors++;
          $display("[TB] FAIL stream_head[%0d]: pc=%h inst=%h required %h/%h",
                   i, inst_pc, inst, exp_q[0], exp_q[0] + 32'h1000);
        end
      end
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stream_stall[%0d]: got %b required 0", i, stall);
      end
      if (i == 2) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h1000) begin
          errors++;
          $display("[TB] FAIL stream_latency: valid=%b pc=%h inst=%h required 1/0/1000",
                   inst_valid, inst_pc, inst);
        end
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] issued[$];
    do_reset();
    stream_en = 1; inst_ready = 0; set_pc(32'h0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (stall !== exp_stall()) begin
        errors++;
        $display("[TB] FAIL bp_stall[%0d]: got %b required %b", i, stall, exp_stall());
      end
      cycle();
    end
    checks++;
    if (stall !== 1'b1 || inst_valid !== 1'b1 || inst_pc !== 32'h0 || pc_addr !== 32'h10) begin
      errors++;
      $display("[TB] FAIL bp_full: stall=%b valid=%b head=%h pc=%h required 1/1/0/10",
               stall, inst_valid, inst_pc, pc_addr);
    end
    inst_ready = 1;
    for (int i = 0; i < 12; i++) begin
      if (inst_valid === 1'b1) issued.push_back(inst_pc);
      checks++;
      if (inst_valid !== (exp_q.size() != 0) || stall !== exp_stall()) begin
        errors++;
        $display("[TB] FAIL bp_drain[%0d]: valid=%b stall=%b required %b/%b",
                 i, inst_valid, stall, exp_q.size() != 0, exp_stall());
      end
      cycle();
    end
    checks++;
    if (issued.size() < 5) begin
      errors++;
      $display("[TB] FAIL bp_count: issued %0d required at least 5", issued.size());
    end
    foreach (issued[k]) begin
      checks++;
      if (issued[k] !== 32'(k * 4)) begin
        errors++;
        $display("[TB] FAIL bp_order[%0d]: got %h required %h", k, issued[k], 32'(k * 4));
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    stream_en = 1; inst_ready = 0; set_pc(32'h0);
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_prefull: stall=%b required 1", stall);
    end
    flush = 1;
    cycle();
    flush = 0;
    set_pc(32'h40);
    checks++;
    if (inst_valid !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_empty: valid=%b stall=%b required 0/0", inst_valid, stall);
    end
    inst_ready = 1;
    cycle();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_f2: valid=%b required 0", inst_valid);
    end
    cycle();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== 32'h1040) begin
      errors++;
      $display("[TB] FAIL flush_redirect: valid=%b pc=%h inst=%h required 1/40/1040",
               inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_end_of_rom();
    logic [31:0] last;
    last = 32'hFFFF_FFFF;
    do_reset();
    stream_en = 1; inst_ready = 1; set_pc(32'h3E0);
    for (int i = 0; i < 14; i++) begin
      if (inst_valid === 1'b1) last = inst_pc;
      checks++;
      if (inst_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("[TB] FAIL eor_valid[%0d]: got %b required %b", i, inst_valid, exp_q.size() != 0);
      end
      cycle();
    end
    checks++;
    if (last !== 32'h3FC || inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL eor_drain: last=%h valid=%b required 3fc/0", last, inst_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    stream_en = 1; set_pc(32'h0);
    for (int i = 0; i < 400; i++) begin
      inst_ready = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      checks++;
      if (inst_valid !== (exp_q.size() != 0) || stall !== exp_stall()) begin
        errors++;
        $display("[TB] FAIL rand_ctl[%0d]: valid=%b stall=%b required %b/%b",
                 i, inst_valid, stall, exp_q.size() != 0, exp_stall());
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (inst_pc !== exp_q[0] || inst !== exp_q[0] + 32'h1000) begin
          errors++;
          $display("[TB] FAIL rand_head[%0d]: pc=%h inst=%h required %h/%h",
                   i, inst_pc, inst, exp_q[0], exp_q[0] + 32'h1000);
        end
      end
      if (flush) begin
        cycle();
        flush = 0;
        set_pc(32'($urandom_range(0, 255)) << 2);
      end else begin
        cycle();
      end
    end
    flush = 0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    stream_en = 1; inst_ready = 0; set_pc(32'h0);
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mrst_pre: valid=%b pc=%h required 1/0", inst_valid, inst_pc);
    end
    rst = 1;
    cycle();
    rst = 0;
    set_pc(32'h0);
    checks++;
    if (stall !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mrst_values: stall=%b valid=%b inst=%h pc=%h required 0/0/0/0",
               stall, inst_valid, inst, inst_pc);
    end
    inst_ready = 1;
    cycle();
    cycle();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h1000) begin
      errors++;
      $display("[TB] FAIL mrst_first: valid=%b pc=%h inst=%h required 1/0/1000",
               inst_valid, inst_pc, inst);
    end
  endtask

  initial begin
    rst = 1; flush = 0; inst_ready = 0; pc_ena = 0; pc_addr = 0;
    cur_pc = 0; stream_en = 0; inflight = 0; inflight_pc = 0;
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_end_of_rom();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
